// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared frontend/memory types and I-cache refill definitions
package mmm_pkg;

    localparam int XLEN            = 64;
    localparam int ICACHE_LINE_LEN = 512;
    localparam int ICACHE_BEAT_W   = 64;

    typedef struct packed {
        logic [XLEN-1:0]            pc;
        logic [ICACHE_LINE_LEN-1:0] line;
    } icache_out_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REFILL,
        DRAIN,
        FILL
    } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache line refill sequencer, optional ICACHE_CRITICAL_WORD_FIRST_EN
module icache_refill_ctrl
    import mmm_pkg::*;
#(
    parameter int LINE_LEN = ICACHE_LINE_LEN,
    parameter int BEAT_W   = ICACHE_BEAT_W
) (
    input  logic              clk_i,
    input  logic              rst_sync_i,
    input  logic              flush_i,
    input  logic              miss_valid_i,
    input  logic [XLEN-1:0]   miss_addr_i,
    output logic              miss_ready_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [XLEN-1:0]   mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [BEAT_W-1:0] mem_rsp_data_i,
    output logic              fill_valid_o,
    output icache_out_t       fill_o,
    input  logic              fill_ready_i,
    output logic              busy_o
);

    localparam int NBEATS = LINE_LEN / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int RCV_W  = CNT_W + 1;
    localparam int LINE_B = LINE_LEN / 8;
    localparam int BEAT_B = BEAT_W / 8;

    refill_state_t       state;
    refill_state_t       state_d;
    logic [CNT_W-1:0]    cnt;
    logic [RCV_W-1:0]    rcv;
    logic [XLEN-1:0]     addr_q;
    logic [LINE_LEN-1:0] line_q;
    logic [CNT_W-1:0]    start_beat;
    logic                last_beat;

    // rcv counts beats actually received, independent of where cnt wrapped to
    assign last_beat = (rcv == RCV_W'(NBEATS - 1));

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    // memory returns the line wrapped starting at the beat holding the missing PC
    assign start_beat     = addr_q[$clog2(LINE_B)-1:$clog2(BEAT_B)];
    assign mem_req_addr_o = addr_q & ~XLEN'(BEAT_B - 1);
`else
    assign start_beat     = '0;
    assign mem_req_addr_o = addr_q & ~XLEN'(LINE_B - 1);
`endif

    assign fill_o.pc   = addr_q & ~XLEN'(LINE_B - 1);
    assign fill_o.line = line_q;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next-state: flush aborts, an accepted request must still have its beats drained
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (miss_valid_i && !flush_i) state_d = REQ;
            end
            REQ: begin
                if (flush_i)              state_d = mem_req_ready_i ? DRAIN : IDLE;
                else if (mem_req_ready_i) state_d = REFILL;
            end
            REFILL: begin
                if (mem_rsp_valid_i && last_beat) state_d = flush_i ? IDLE : FILL;
                else if (flush_i)                 state_d = DRAIN;
            end
            DRAIN: begin
                if (mem_rsp_valid_i && last_beat) state_d = IDLE;
            end
            FILL: begin
                if (flush_i || fill_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs: fill_valid_o is withdrawn in the flush cycle so no write can slip through
    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        fill_valid_o    = 1'b0;
        busy_o          = 1'b1;
        case (state)
            IDLE: begin
                miss_ready_o = 1'b1;
                busy_o       = 1'b0;
            end
            REQ:     mem_req_valid_o = 1'b1;
            FILL:    fill_valid_o    = !flush_i;
            default: ;
        endcase
    end

    // address latch, beat counters and line buffer
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            cnt    <= '0;
            rcv    <= '0;
            addr_q <= '0;
            line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid_i && !flush_i) addr_q <= miss_addr_i;
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        cnt <= start_beat;
                        rcv <= '0;
                    end
                end
                REFILL, DRAIN: begin
                    if (mem_rsp_valid_i) begin
                        if (state == REFILL) line_q[int'(cnt)*BEAT_W +: BEAT_W] <= mem_rsp_data_i;
                        cnt <= (cnt == CNT_W'(NBEATS - 1)) ? '0 : cnt + CNT_W'(1);
                        rcv <= rcv + RCV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // a beat with no refill outstanding is dropped; flag it during simulation
    always_ff @(posedge clk_i) begin
        if (!rst_sync_i && mem_rsp_valid_i && (state == IDLE || state == REQ))
            $warning("icache_refill_ctrl: response beat with no refill outstanding, ignored");
    end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
`timescale 1ns/1ps
module tb_icache_refill_ctrl;
    import mmm_pkg::*;

    localparam int NB = 8;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            miss_valid;
    logic [XLEN-1:0] miss_addr;
    logic            miss_ready;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [63:0]     rsp_data;
    logic            fill_valid;
    icache_out_t     fill;
    logic            fill_ready;
    logic            busy;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk_i          (clk),
        .rst_sync_i     (rst),
        .flush_i        (flush),
        .miss_valid_i   (miss_valid),
        .miss_addr_i    (miss_addr),
        .miss_ready_o   (miss_ready),
        .mem_req_valid_o(req_valid),
        .mem_req_ready_i(req_ready),
        .mem_req_addr_o (req_addr),
        .mem_rsp_valid_i(rsp_valid),
        .mem_rsp_data_i (rsp_data),
        .fill_valid_o   (fill_valid),
        .fill_o         (fill),
        .fill_ready_i   (fill_ready),
        .busy_o         (busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    logic            exp_miss_ready, exp_req_valid, exp_fill, exp_busy;
    logic [XLEN-1:0] exp_req_addr;
    icache_out_t     exp_out;

    // memory image of the line being refilled, indexed by slice
    logic [63:0]     mem_line [NB];
    logic [XLEN-1:0] last_req_addr;
    icache_out_t     last_fill;
    int              last_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [XLEN-1:0] req_addr_of(input logic [XLEN-1:0] a);
        return CWF ? (a / 8) * 8 : (a / 64) * 64;
    endfunction

    function automatic int start_of(input logic [XLEN-1:0] a);
        return CWF ? int'((a % 64) / 8) : 0;
    endfunction

    function automatic logic [511:0] mem_packed();
        logic [511:0] l;
        for (int s = 0; s < NB; s++) l[s*64 +: 64] = mem_line[s];
        return l;
    endfunction

    // 0 idle, 1 request outstanding, 2 collecting or draining beats, 3 line presented
    task automatic set_exp(input int ph);
        exp_miss_ready = (ph == 0);
        exp_req_valid  = (ph == 1);
        exp_fill       = (ph == 3);
        exp_busy       = (ph != 0);
    endtask

    // compare DUT against the model on every cycle, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("miss_ready", 512'(miss_ready), 512'(exp_miss_ready));
            chk("req_valid", 512'(req_valid), 512'(exp_req_valid));
            chk("fill_valid", 512'(fill_valid), 512'(exp_fill && !flush));
            chk("busy", 512'(busy), 512'(exp_busy));
            if (exp_req_valid) chk("req_addr", 512'(req_addr), 512'(exp_req_addr));
            if (exp_fill) begin
                chk("fill_pc", 512'(fill.pc), 512'(exp_out.pc));
                chk("fill_line", fill.line, exp_out.line);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush      = 1'b0;
        miss_valid = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        fill_ready = 1'b0;
        miss_addr  = {$urandom, $urandom};
        rsp_data   = {$urandom, $urandom};
    endtask

    task automatic set_mem_seq();
        for (int s = 0; s < NB; s++) mem_line[s] = 64'hB0 + 64'(s);
    endtask

    task automatic set_mem_rand();
        for (int s = 0; s < NB; s++) mem_line[s] = {$urandom, $urandom};
    endtask

    // mode: 0 normal, 1 flush in REQ unaccepted, 2 flush in REQ accepted,
    //       3 flush before beat fk, 4 flush with beat fk, 5 flush in FILL at wait fk
    task automatic do_refill(input logic [XLEN-1:0] addr, input int mode, input int fk,
                             input int req_dly, input int max_gap, input int fill_dly);
        int  t0;
        int  st;
        bit  drained;
        st = start_of(addr);
        set_exp(0);
        quiet();
        miss_valid = 1'b1;
        miss_addr  = addr;
        t0 = cyc;
        tick();
        miss_valid   = 1'($urandom_range(0, 1));
        miss_addr    = {$urandom, $urandom};
        exp_req_addr = req_addr_of(addr);
        set_exp(1);
        last_req_addr = req_addr;
        for (int i = 0; i < req_dly; i++) tick();
        if (mode == 1) begin
            flush = 1'b1;
            tick();
            quiet();
            set_exp(0);
            return;
        end
        req_ready = 1'b1;
        flush     = (mode == 2);
        drained   = (mode == 2);
        tick();
        req_ready = 1'b0;
        flush     = 1'b0;
        set_exp(2);
        for (int k = 0; k < NB; k++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) tick();
            if (mode == 3 && k == fk) begin
                flush   = 1'b1;
                drained = 1'b1;
                tick();
                flush = 1'b0;
            end
            rsp_valid = 1'b1;
            rsp_data  = mem_line[(st + k) % NB];
            if (mode == 4 && k == fk) begin
                flush   = 1'b1;
                drained = 1'b1;
            end
            tick();
            rsp_valid = 1'b0;
            flush     = 1'b0;
        end
        if (drained) begin
            quiet();
            set_exp(0);
            return;
        end
        exp_out.pc   = (addr / 64) * 64;
        exp_out.line = mem_packed();
        set_exp(3);
        last_lat  = cyc - t0;
        last_fill = fill;
        for (int w = 0; w < fill_dly; w++) begin
            if (mode == 5 && w == fk) begin
                flush      = 1'b1;
                fill_ready = 1'($urandom_range(0, 1));
                tick();
                quiet();
                set_exp(0);
                return;
            end
            tick();
        end
        fill_ready = 1'b1;
        tick();
        quiet();
        set_exp(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        quiet();
        set_exp(0);
        exp_req_addr = '0;
        exp_out      = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_miss_ready", 512'(miss_ready), 512'(1));
        chk("rst_req_valid", 512'(req_valid), 512'(0));
        chk("rst_fill_valid", 512'(fill_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk_en = 1'b1;
        tick();

        // flush beats a simultaneous miss
        miss_valid = 1'b1;
        flush      = 1'b1;
        miss_addr  = 64'h4000;
        tick();
        quiet();
        tick();

        // nominal refill, back-to-back beats
        set_mem_seq();
        do_refill(64'h1044, 0, 0, 0, 0, 0);
        chk("t1_latency", 512'(last_lat), 512'(10));
        chk("t1_req_addr", 512'(last_req_addr), 512'(64'h1040));
        chk("t1_pc", 512'(last_fill.pc), 512'(64'h1040));
        chk("t1_beat0", 512'(last_fill.line[63:0]), 512'(64'hB0));
        chk("t1_beat7", 512'(last_fill.line[511:448]), 512'(64'hB7));
        tick();

        // miss in the middle of a beat: critical word first when enabled
        do_refill(64'h1058, 0, 0, 0, 0, 0);
        chk("t2_req_addr", 512'(last_req_addr), 512'(CWF ? 64'h1058 : 64'h1040));
        chk("t2_pc", 512'(last_fill.pc), 512'(64'h1040));
        chk("t2_beat3", 512'(last_fill.line[255:192]), 512'(64'hB3));
        chk("t2_beat0", 512'(last_fill.line[63:0]), 512'(64'hB0));

        // flush after beat 3, then a clean refill
        set_mem_rand();
        do_refill(64'h1040, 3, 4, 0, 0, 0);
        set_mem_rand();
        do_refill(64'h2000, 0, 0, 0, 0, 0);

        // flush in REQ, without and with the request accepted
        do_refill(64'h2080, 1, 0, 1, 0, 0);
        do_refill(64'h20C0, 2, 0, 0, 0, 0);
        set_mem_rand();
        do_refill(64'h2100, 0, 0, 0, 1, 0);

        // fill backpressure, then flush while the line is presented
        set_mem_rand();
        do_refill(64'h3000, 0, 0, 0, 0, 5);
        set_mem_rand();
        do_refill(64'h3040, 5, 3, 0, 0, 5);

        // reset after beat 2, later beats arrive in IDLE
        set_mem_rand();
        miss_valid = 1'b1;
        miss_addr  = 64'h5000;
        tick();
        miss_valid   = 1'b0;
        exp_req_addr = req_addr_of(64'h5000);
        set_exp(1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        set_exp(2);
        for (int k = 0; k < 3; k++) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_line[k];
            tick();
        end
        rsp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_exp(0);
        for (int k = 3; k < NB; k++) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_line[k];
            tick();
        end
        quiet();
        tick();
        set_mem_rand();
        do_refill(64'h5040, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            int mode, fk, fd;
            mode = $urandom_range(0, 5);
            fk   = (mode == 5) ? $urandom_range(0, 3) : $urandom_range(0, NB - 1);
            fd   = (mode == 5) ? fk + 1 + $urandom_range(0, 2) : $urandom_range(0, 4);
            set_mem_rand();
            do_refill({$urandom, $urandom}, mode, fk, $urandom_range(0, 3), $urandom_range(0, 2), fd);
            for (int i = 0, n = $urandom_range(0, 2); i < n; i++) begin
                flush = 1'($urandom_range(0, 1));
                tick();
            end
            quiet();
        end

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
